// File: rtl/psw_context_ctrl_pkg.sv
// Shared definitions for the PSW/PC context save/restore controller:
// default bus parameters, sequencer state encoding and a state classifier.
package psw_context_ctrl_pkg;

    localparam int          DATA_W_DEF      = 16;
    localparam logic [15:0] VECTOR_ADDR_DEF = 16'h0010;
    localparam logic [7:0]  ACK_TIMEOUT_DEF = 8'd15;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PUSH_PSW = 3'd1,
        ST_PUSH_PC  = 3'd2,
        ST_VECTOR   = 3'd3,
        ST_INC_PC   = 3'd4,
        ST_POP_PC   = 3'd5,
        ST_INC_PSW  = 3'd6,
        ST_POP_PSW  = 3'd7
    } state_t;

    // States that hold a stack request open until mem_ack arrives.
    function automatic logic is_wait_state(input state_t s);
        return (s == ST_PUSH_PSW) || (s == ST_PUSH_PC) ||
               (s == ST_POP_PC)   || (s == ST_POP_PSW);
    endfunction

endpackage

// File: rtl/psw_context_ctrl_ack_timer.sv
// Wait-cycle counter for stack accesses; flags expiry when the count
// reaches the configured timeout and holds there until cleared.
module psw_context_ctrl_ack_timer
    import psw_context_ctrl_pkg::*;
#(
    parameter logic [7:0] TIMEOUT = ACK_TIMEOUT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    logic [7:0] r_count;
    logic       w_expired;

    assign w_expired = (r_count == TIMEOUT);
    assign o_expired = w_expired;

    // Count wait cycles; saturate at expiry so err cannot be missed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= 8'd0;
        end else if (i_clr) begin
            r_count <= 8'd0;
        end else if (i_en && !w_expired) begin
            r_count <= r_count + 8'd1;
        end else begin
            r_count <= r_count;
        end
    end

endmodule

// File: rtl/psw_context_ctrl.sv
// Sequences PSW/PC push on interrupt entry and pop on RTI, drives the W-bus
// and stack strobes, and owns the interrupt-enable flag.
module psw_context_ctrl
    import psw_context_ctrl_pkg::*;
#(
    parameter int                DATA_W      = DATA_W_DEF,
    parameter logic [DATA_W-1:0] VECTOR_ADDR = VECTOR_ADDR_DEF,
    parameter logic [7:0]        ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              irq,
    input  logic              instr_done,
    input  logic              rti,
    input  logic              ei,
    input  logic              di,
    input  logic              mem_ack,
    output logic              psw_enable,
    output logic              psw_latch,
    output logic              pc_enable,
    output logic              pc_latch,
    output logic              vec_enable,
    output logic [DATA_W-1:0] vec_bus,
    output logic              mem_wr,
    output logic              mem_rd,
    output logic              sp_dec,
    output logic              sp_inc,
    output logic              irq_ack,
    output logic              ie,
    output logic              busy,
    output logic              err
);

    state_t r_state;
    state_t w_next_state;
    logic   r_ie;
    logic   w_expired;
    logic   w_timer_clr;
    logic   w_timer_en;
    logic   w_ie_set;
    logic   w_psw_enable, w_psw_latch, w_pc_enable, w_pc_latch, w_vec_enable;
    logic   w_mem_wr, w_mem_rd, w_sp_dec, w_sp_inc, w_irq_ack, w_err;

    assign w_timer_clr = (w_next_state != r_state) || !is_wait_state(r_state);
    assign w_timer_en  = is_wait_state(r_state) && !mem_ack;

    psw_context_ctrl_ack_timer #(
        .TIMEOUT (ACK_TIMEOUT)
    ) u_ack_timer (
        .clk       (clk),
        .reset     (reset),
        .i_clr     (w_timer_clr),
        .i_en      (w_timer_en),
        .o_expired (w_expired)
    );

    // Next-state and strobe decode; an ack always beats a simultaneous expiry.
    always_comb begin
        w_next_state = r_state;
        w_psw_enable = 1'b0;
        w_psw_latch  = 1'b0;
        w_pc_enable  = 1'b0;
        w_pc_latch   = 1'b0;
        w_vec_enable = 1'b0;
        w_mem_wr     = 1'b0;
        w_mem_rd     = 1'b0;
        w_sp_dec     = 1'b0;
        w_sp_inc     = 1'b0;
        w_irq_ack    = 1'b0;
        w_err        = 1'b0;
        w_ie_set     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (rti) begin
                    w_next_state = ST_INC_PC;
                end else if (instr_done && irq && r_ie) begin
                    w_next_state = ST_PUSH_PSW;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_PUSH_PSW: begin
                w_psw_enable = 1'b1;
                w_mem_wr     = 1'b1;
                if (mem_ack) begin
                    w_sp_dec     = 1'b1;
                    w_next_state = ST_PUSH_PC;
                end else if (w_expired) begin
                    w_err        = 1'b1;
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_PUSH_PSW;
                end
            end
            ST_PUSH_PC: begin
                w_pc_enable = 1'b1;
                w_mem_wr    = 1'b1;
                if (mem_ack) begin
                    w_sp_dec     = 1'b1;
                    w_next_state = ST_VECTOR;
                end else if (w_expired) begin
                    w_err        = 1'b1;
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_PUSH_PC;
                end
            end
            ST_VECTOR: begin
                w_vec_enable = 1'b1;
                w_pc_latch   = 1'b1;
                w_irq_ack    = 1'b1;
                w_next_state = ST_IDLE;
            end
            ST_INC_PC: begin
                w_sp_inc     = 1'b1;
                w_next_state = ST_POP_PC;
            end
            ST_POP_PC: begin
                w_mem_rd = 1'b1;
                if (mem_ack) begin
                    w_pc_latch   = 1'b1;
                    w_next_state = ST_INC_PSW;
                end else if (w_expired) begin
                    w_err        = 1'b1;
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_POP_PC;
                end
            end
            ST_INC_PSW: begin
                w_sp_inc     = 1'b1;
                w_next_state = ST_POP_PSW;
            end
            ST_POP_PSW: begin
                w_mem_rd = 1'b1;
                if (mem_ack) begin
                    w_psw_latch  = 1'b1;
                    w_ie_set     = 1'b1;
                    w_next_state = ST_IDLE;
                end else if (w_expired) begin
                    w_err        = 1'b1;
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_POP_PSW;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Interrupt enable: sequence-driven updates override ei/di, di beats ei.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ie <= 1'b0;
        end else if (r_state == ST_VECTOR) begin
            r_ie <= 1'b0;
        end else if (w_ie_set) begin
            r_ie <= 1'b1;
        end else if (di) begin
            r_ie <= 1'b0;
        end else if (ei) begin
            r_ie <= 1'b1;
        end else begin
            r_ie <= r_ie;
        end
    end

    assign psw_enable = w_psw_enable;
    assign psw_latch  = w_psw_latch;
    assign pc_enable  = w_pc_enable;
    assign pc_latch   = w_pc_latch;
    assign vec_enable = w_vec_enable;
    assign vec_bus    = w_vec_enable ? VECTOR_ADDR : {DATA_W{1'b0}};
    assign mem_wr     = w_mem_wr;
    assign mem_rd     = w_mem_rd;
    assign sp_dec     = w_sp_dec;
    assign sp_inc     = w_sp_inc;
    assign irq_ack    = w_irq_ack;
    assign ie         = r_ie;
    assign busy       = (r_state != ST_IDLE);
    assign err        = w_err;

endmodule
